// File: rtl/set_pkg.sv
// set_pkg: shared widths and FSM state encoding for set_job_scheduler.
package set_pkg;
  localparam int CENTRAL_W = 16;
  localparam int RADIUS_W = 8;
  localparam int CAND_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N_REQ]) gnt_id = ID_W'((int'(ptr) + k) % N_REQ);
    gnt[gnt_id] = |req;
  end
endmodule

// File: rtl/set_job_scheduler.sv
// set_job_scheduler: round-robin sharing of one SET engine among N_REQ requesters.
// Optional watchdog in WAIT enabled by defining SET_WDOG_EN.
module set_job_scheduler
  import set_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*CENTRAL_W-1:0] req_central,
  input  logic [N_REQ*RADIUS_W-1:0] req_radius,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      set_en,
  output logic [CENTRAL_W-1:0]      set_central,
  output logic [RADIUS_W-1:0]       set_radius,
  input  logic                      set_busy,
  input  logic                      set_valid,
  input  logic [CAND_W-1:0]         set_candidate,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ID_W-1:0]           res_id,
  output logic [CAND_W-1:0]         res_candidate,
  output logic                      res_timeout,
  output logic                      sched_busy
);
  state_t state;
  logic [ID_W-1:0] rr_ptr, gnt_id;
  logic [N_REQ-1:0] gnt;
  logic [CENTRAL_W-1:0] lat_central;
  logic [RADIUS_W-1:0] lat_radius;
  logic wd_hit;
  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid), .ptr(rr_ptr), .gnt(gnt), .gnt_id(gnt_id)
  );
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign res_valid = state == RESP;
  assign sched_busy = state != IDLE;
`ifdef SET_WDOG_EN
  logic [15:0] wd_cnt;
  always_ff @(posedge clk)
    wd_cnt <= (rst || state != WAIT) ? 16'd0 : wd_cnt + 16'd1;
  assign wd_hit = state == WAIT && wd_cnt == 16'(TIMEOUT_CYCLES - 1);
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      res_id <= '0;
      lat_central <= '0;
      lat_radius <= '0;
      set_en <= 1'b0;
      set_central <= '0;
      set_radius <= '0;
      res_candidate <= '0;
      res_timeout <= 1'b0;
    end else begin
      set_en <= 1'b0;
      set_central <= '0;
      set_radius <= '0;
      case (state)
        IDLE: if (|req_valid) begin
          res_id <= gnt_id;
          lat_central <= req_central[CENTRAL_W*gnt_id +: CENTRAL_W];
          lat_radius <= req_radius[RADIUS_W*gnt_id +: RADIUS_W];
          state <= ISSUE;
        end
        ISSUE: if (!set_busy) begin
          set_en <= 1'b1;
          set_central <= lat_central;
          set_radius <= lat_radius;
          state <= WAIT;
        end
        WAIT: if (set_valid || wd_hit) begin
          res_candidate <= set_valid ? set_candidate : '0;
          res_timeout <= !set_valid;
          state <= RESP;
        end
        RESP: if (res_ready) begin
          rr_ptr <= ID_W'((int'(res_id) + 1) % N_REQ);
          res_timeout <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
